// File: rtl/wrf_traffic_checker.sv
// wrf_traffic_checker: receive-side checker for generated WR fabric test traffic.
// Parses header, sequence ID and ramp payload; keeps frame/error/gap counters.
module wrf_traffic_checker #(
    parameter logic [15:0] g_ethertype = 16'h88f7,
    parameter int          g_max_bytes = 1536,
    parameter int          g_min_bytes = 60
) (
    input  logic        clk_sys_i,
    input  logic        rst_i,
    input  logic [15:0] snk_dat_i,
    input  logic [1:0]  snk_adr_i,
    input  logic [1:0]  snk_sel_i,
    input  logic        snk_cyc_i,
    input  logic        snk_stb_i,
    input  logic        snk_we_i,
    output logic        snk_stall_o,
    output logic        snk_ack_o,
    output logic        snk_err_o,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [47:0] dst_mac_i,
    output logic [31:0] frames_o,
    output logic [15:0] err_frames_o,
    output logic [15:0] seq_gaps_o,
    output logic        frame_done_p_o,
    output logic        frame_err_p_o
);
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DONE} state_t;

    localparam logic [15:0] BytesSat = 16'(g_max_bytes + 2);
    localparam logic [15:0] BytesMax = 16'(g_max_bytes);
    localparam logic [15:0] BytesMin = 16'(g_min_bytes);

    state_t      state, state_n;
    logic        cyc_d;
    logic [10:0] wcnt, wcnt_n, idx;
    logic [15:0] bytes, bytes_n, inc;
    logic        err, err_n, vlan, vlan_n, half, half_n;
    logic        seq_seen, seq_seen_n;
    logic [15:0] seq_id, seq_id_n, seq_ref, mac_w, exp_w;
    logic [7:0]  pb, pb_n;
    logic        ref_valid;
    logic        accept, start, in_frame, data_w, stat_w, hdr, frame_err;

    assign snk_err_o   = 1'b0;
    assign snk_stall_o = rst_i | (state == DONE);
    assign accept      = snk_cyc_i & snk_stb_i & snk_we_i & ~snk_stall_o;
    // The word strobed on the rising edge of cyc is header word 0.
    assign start    = (state == IDLE) & snk_cyc_i & ~cyc_d & en_i;
    assign hdr      = start | (state == HDR);
    assign in_frame = hdr | (state == PAYLOAD);
    assign data_w   = accept & in_frame & (snk_adr_i == 2'd0);
    assign stat_w   = accept & in_frame & (snk_adr_i == 2'd2);
    assign idx      = start ? 11'd0 : wcnt;

    assign frame_err = err | (bytes < BytesMin) | (bytes > BytesMax) | ~seq_seen;

    always_comb begin
        mac_w = dst_mac_i[15:0];
        if (idx == 11'd0)      mac_w = dst_mac_i[47:32];
        else if (idx == 11'd1) mac_w = dst_mac_i[31:16];
        inc = (snk_sel_i == 2'b11) ? 16'd2 :
              (snk_sel_i == 2'b10) ? 16'd1 : 16'd0;
    end

    always_comb begin
        state_n    = state;
        wcnt_n     = idx;
        err_n      = start ? 1'b0 : err;
        vlan_n     = start ? 1'b0 : vlan;
        half_n     = start ? 1'b0 : half;
        seq_seen_n = start ? 1'b0 : seq_seen;
        bytes_n    = start ? 16'd0 : bytes;
        pb_n       = start ? 8'd0 : pb;
        seq_id_n   = seq_id;
        exp_w      = {pb_n, pb_n + 8'd1};
        unique case (state)
            IDLE:         if (start) state_n = HDR;
            HDR, PAYLOAD: if (!snk_cyc_i) state_n = DONE;
            DONE:         state_n = IDLE;
        endcase
        if (stat_w && snk_dat_i[1]) err_n = 1'b1;
        if (data_w) begin
            if (half_n) err_n = 1'b1;
            if (snk_sel_i == 2'b10) half_n = 1'b1;
            bytes_n = (bytes_n + inc >= BytesSat) ? BytesSat : bytes_n + inc;
            if (hdr) begin
                wcnt_n = idx + 11'd1;
                case (idx)
                    11'd0, 11'd1, 11'd2: if (snk_dat_i != mac_w) err_n = 1'b1;
                    11'd6: begin
                        if (snk_dat_i == 16'h8100) vlan_n = 1'b1;
                        else begin
                            if (snk_dat_i != g_ethertype) err_n = 1'b1;
                            state_n = PAYLOAD;
                        end
                    end
                    11'd8: begin
                        if (snk_dat_i != g_ethertype) err_n = 1'b1;
                        state_n = PAYLOAD;
                    end
                    default: ;
                endcase
            end else if (!seq_seen_n) begin
                seq_id_n   = snk_dat_i;
                seq_seen_n = 1'b1;
            end else begin
                if (snk_sel_i == 2'b11 && snk_dat_i != exp_w) err_n = 1'b1;
                if (snk_sel_i == 2'b10 && snk_dat_i[15:8] != exp_w[15:8]) err_n = 1'b1;
                pb_n = pb_n + 8'd2;
            end
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            cyc_d          <= 1'b1;
            wcnt           <= '0;
            bytes          <= '0;
            err            <= 1'b0;
            vlan           <= 1'b0;
            half           <= 1'b0;
            seq_seen       <= 1'b0;
            seq_id         <= '0;
            pb             <= '0;
            seq_ref        <= '0;
            ref_valid      <= 1'b0;
            snk_ack_o      <= 1'b0;
            frames_o       <= '0;
            err_frames_o   <= '0;
            seq_gaps_o     <= '0;
            frame_done_p_o <= 1'b0;
            frame_err_p_o  <= 1'b0;
        end else begin
            state          <= state_n;
            cyc_d          <= snk_cyc_i;
            wcnt           <= wcnt_n;
            bytes          <= bytes_n;
            err            <= err_n;
            vlan           <= vlan_n;
            half           <= half_n;
            seq_seen       <= seq_seen_n;
            seq_id         <= seq_id_n;
            pb             <= pb_n;
            snk_ack_o      <= accept;
            frame_done_p_o <= (state == DONE);
            frame_err_p_o  <= (state == DONE) & frame_err;
            // A clear coinciding with DONE drops that frame from the counters.
            if (clr_i) begin
                frames_o     <= '0;
                err_frames_o <= '0;
                seq_gaps_o   <= '0;
                ref_valid    <= 1'b0;
            end else if (state == DONE) begin
                frames_o <= frames_o + 32'd1;
                if (frame_err && err_frames_o != 16'hffff)
                    err_frames_o <= err_frames_o + 16'd1;
                if (seq_seen) begin
                    if (ref_valid && seq_id != seq_ref + 16'd1 && seq_gaps_o != 16'hffff)
                        seq_gaps_o <= seq_gaps_o + 16'd1;
                    seq_ref   <= seq_id;
                    ref_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_wrf_traffic_checker.sv
// tb_wrf_traffic_checker: directed frames with a per-frame expectation queue
// checked by a monitor on every frame_done_p_o pulse.
module tb_wrf_traffic_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dat = '0;
    logic [1:0]  adr = '0;
    logic [1:0]  sel = 2'b11;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b1;
    logic        stall, ack, werr;
    logic        en = 1'b1, clr = 1'b0;
    logic [47:0] mac = 48'h1150_cafe_babe;
    logic [31:0] frames;
    logic [15:0] err_frames, seq_gaps;
    logic        done_p, err_p;

    wrf_traffic_checker dut (
        .clk_sys_i(clk), .rst_i(rst),
        .snk_dat_i(dat), .snk_adr_i(adr), .snk_sel_i(sel),
        .snk_cyc_i(cyc), .snk_stb_i(stb), .snk_we_i(we),
        .snk_stall_o(stall), .snk_ack_o(ack), .snk_err_o(werr),
        .en_i(en), .clr_i(clr), .dst_mac_i(mac),
        .frames_o(frames), .err_frames_o(err_frames), .seq_gaps_o(seq_gaps),
        .frame_done_p_o(done_p), .frame_err_p_o(err_p)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] frames;
        logic [15:0] errs;
        logic [15:0] gaps;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0, fails = 0;
    int          n_strobe = 0, n_ack = 0, n_pulse = 0, ack_bad = 0;
    logic        prev_acc = 1'b0;
    logic [31:0] m_frames = 0;
    logic [15:0] m_errs = 0, m_gaps = 0, m_ref = 0;
    bit          m_ref_ok = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack !== prev_acc) ack_bad++;
        if (ack) n_ack++;
        prev_acc = cyc & stb & we & ~rst;
        if (done_p) begin
            n_pulse++;
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL pulse: got unexpected frame_done_p_o, expected none");
            end else begin
                mon_e = sb.pop_front();
                chk("err_p", {31'd0, err_p}, {31'd0, mon_e.err});
                chk("frames", frames, mon_e.frames);
                chk("err_frames", {16'd0, err_frames}, {16'd0, mon_e.errs});
                chk("seq_gaps", {16'd0, seq_gaps}, {16'd0, mon_e.gaps});
            end
        end else if (err_p) begin
            tests++; fails++;
            $display("FAIL err_p_alone: got 1, expected 0");
        end
    end

    task automatic build(input int nbytes, input logic [15:0] id, input int bad_k,
                         input bit vlan, output logic [15:0] w[$], output logic [1:0] s[$]);
        int p;
        logic [7:0] b;
        w = {};
        s = {};
        w.push_back(mac[47:32]);
        w.push_back(mac[31:16]);
        w.push_back(mac[15:0]);
        w.push_back(16'h0a0b);
        w.push_back(16'h0c0d);
        w.push_back(16'h0e0f);
        if (vlan) begin
            w.push_back(16'h8100);
            w.push_back(16'h0064);
        end
        w.push_back(16'h88f7);
        w.push_back(id);
        p = nbytes - (vlan ? 18 : 14) - 2;
        for (int k = 0; k < p / 2; k++) begin
            b = 8'(2 * k);
            w.push_back({b, b + 8'd1} ^ ((k == bad_k) ? 16'h0001 : 16'h0000));
        end
        if (p % 2 == 1) begin
            b = 8'(2 * (p / 2));
            w.push_back({b, 8'ha5});
        end
        for (int i = 0; i < w.size(); i++)
            s.push_back((i == w.size() - 1 && p % 2 == 1) ? 2'b10 : 2'b11);
    endtask

    task automatic drive(input logic [15:0] w[$], input logic [1:0] s[$]);
        @(posedge clk); #1;
        cyc = 1'b1;
        foreach (w[i]) begin
            stb = 1'b1; dat = w[i]; sel = s[i];
            n_strobe++;
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0; sel = 2'b11;
    endtask

    task automatic send_frame(input int nbytes, input logic [15:0] id, input int bad_k,
                              input bit vlan, input bit exp_err, input bit clr_done);
        logic [15:0] w[$];
        logic [1:0]  s[$];
        exp_t e;
        build(nbytes, id, bad_k, vlan, w, s);
        if (clr_done) begin
            m_frames = 0; m_errs = 0; m_gaps = 0; m_ref_ok = 0;
        end else begin
            m_frames++;
            if (exp_err && m_errs != 16'hffff) m_errs++;
            if (m_ref_ok && id != m_ref + 16'd1 && m_gaps != 16'hffff) m_gaps++;
            m_ref = id; m_ref_ok = 1;
        end
        e.err = exp_err; e.frames = m_frames; e.errs = m_errs; e.gaps = m_gaps;
        sb.push_back(e);
        drive(w, s);
        @(posedge clk); #1;
        chk("stall_done", {31'd0, stall}, 32'd1);
        clr = clr_done;
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic clear_idle();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        m_frames = 0; m_errs = 0; m_gaps = 0; m_ref_ok = 0;
        chk("frames_after_clr", frames, 32'd0);
    endtask

    initial begin
        logic [15:0] w[$];
        logic [1:0]  s[$];
        logic [15:0] wa[$];
        logic [1:0]  sa[$];

        repeat (3) @(negedge clk);
        chk("stall_in_reset", {31'd0, stall}, 32'd1);
        chk("ack_in_reset", {31'd0, ack}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("stall_idle", {31'd0, stall}, 32'd0);
        chk("frames_reset", frames, 32'd0);
        chk("errs_reset", {16'd0, err_frames, seq_gaps}, 32'd0);
        chk("werr", {31'd0, werr}, 32'd0);

        for (int i = 0; i < 100; i++)
            send_frame(64 + (i * 37) % 194, 16'(i), -1, 0, 0, 0);
        chk("clean_frames", frames, 32'd100);
        chk("clean_errs", {16'd0, err_frames}, 32'd0);
        chk("clean_gaps", {16'd0, seq_gaps}, 32'd0);
        chk("clean_pulses", n_pulse, 32'd100);
        chk("clean_acks", n_ack, n_strobe);

        send_frame(65, 16'd100, -1, 0, 0, 0);

        for (int i = 0; i < 10; i++)
            send_frame(64, 16'(101 + i), (i == 3) ? 5 : -1, 0, (i == 3), 0);
        chk("corrupt_errs", {16'd0, err_frames}, 32'd1);
        chk("corrupt_frames", frames, 32'd111);

        clear_idle();
        send_frame(64, 16'd0, -1, 0, 0, 0);
        send_frame(64, 16'd1, -1, 0, 0, 0);
        send_frame(64, 16'd2, -1, 0, 0, 0);
        send_frame(64, 16'd5, -1, 0, 0, 0);
        send_frame(64, 16'd6, -1, 0, 0, 0);
        chk("gap_gaps", {16'd0, seq_gaps}, 32'd1);
        chk("gap_errs", {16'd0, err_frames}, 32'd0);

        send_frame(58, 16'd7, -1, 0, 1, 0);
        send_frame(1540, 16'd8, -1, 0, 1, 0);
        send_frame(80, 16'd9, -1, 1, 0, 0);
        chk("limit_errs", {16'd0, err_frames}, 32'd2);

        for (int i = 0; i < 5; i++)
            send_frame(64, 16'(10 + i), -1, 0, 0, (i == 4));
        chk("clr_done_frames", frames, 32'd0);
        send_frame(64, 16'd200, -1, 0, 0, 0);
        chk("after_clr_frames", frames, 32'd1);
        chk("after_clr_gaps", {16'd0, seq_gaps}, 32'd0);

        // Reset in the middle of a frame; the tail must be acked but not counted.
        build(64, 16'd250, -1, 0, w, s);
        @(posedge clk); #1;
        cyc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stb = 1'b1; dat = w[i]; sel = s[i]; n_strobe++;
            @(posedge clk); #1;
        end
        stb = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        m_frames = 0; m_errs = 0; m_gaps = 0; m_ref_ok = 0;
        @(negedge clk);
        chk("stall_mid_rst", {31'd0, stall}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_frames", frames, 32'd0);
        chk("rst_outputs", {16'd0, err_frames, seq_gaps}, 32'd0);
        @(posedge clk); #1;
        for (int i = 10; i < w.size(); i++) begin
            stb = 1'b1; dat = w[i]; sel = s[i]; n_strobe++;
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("tail_not_counted", frames, 32'd0);
        send_frame(64, 16'd300, -1, 0, 0, 0);
        chk("post_rst_frames", frames, 32'd1);

        en = 1'b0;
        build(64, 16'd999, 2, 0, wa, sa);
        drive(wa, sa);
        repeat (3) @(posedge clk);
        #1 en = 1'b1;
        chk("disabled_frames", frames, 32'd1);
        send_frame(64, 16'd301, -1, 0, 0, 0);
        chk("enabled_frames", frames, 32'd2);
        chk("enabled_gaps", {16'd0, seq_gaps}, 32'd0);

        repeat (3) @(posedge clk);
        chk("queue_drained", sb.size(), 32'd0);
        chk("ack_timing", ack_bad, 32'd0);
        chk("ack_count", n_ack, n_strobe);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
